alu_issue: RTL

- Initiator side of the ALU interface: decodes ALUOp/funct3/funct7 into the 4-bit ALU Operation code and selects operands.
- Drives SrcA/SrcB/Operation/Jalr from a registered issue stage, then captures ALUResult into a result register.
- Sits between decode and writeback/branch logic, with a two-stage valid/ready pipeline, backpressure and flush.

---
 rtl/alu_issue_pkg.sv | 50 +++++
 rtl/alu_issue_decode.sv | 59 +++++
 rtl/alu_issue.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared types for the ALU issue block (ALUOp codes, ALU Operation
// encodings, issue-stage record).
package alu_issue_pkg;

   localparam int unsigned ISSUE_XLEN = 32;

   typedef enum logic [1:0] {
      ALU_OP_MEM    = 2'b00,
      ALU_OP_BRANCH = 2'b01,
      ALU_OP_ARITH  = 2'b10,
      ALU_OP_LUI    = 2'b11
   } alu_op_e;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0011,
      OP_XOR = 4'b0100,
      OP_SLT = 4'b0101,
      OP_LUI = 4'b0110,
      OP_SRL = 4'b0111,
      OP_BEQ = 4'b1000,
      OP_SLL = 4'b1001,
      OP_SRA = 4'b1010,
      OP_BLT = 4'b1100,
      OP_BGE = 4'b1111
   } alu_opcode_e;

   typedef struct packed {
      logic [ISSUE_XLEN-1:0] src_a;
      logic [ISSUE_XLEN-1:0] src_b;
      alu_opcode_e           op;
      logic                  jalr;
      logic                  bne_inv;
      logic                  is_branch;
      logic                  illegal;
      logic [4:0]            rd;
   } issue_s1_t;

   localparam issue_s1_t ISSUE_S1_RST = '{
      src_a: '0, src_b: '0, op: OP_ADD, jalr: 1'b0,
      bne_inv: 1'b0, is_branch: 1'b0, illegal: 1'b0, rd: '0
   };

   function automatic logic is_shift_op(input alu_opcode_e op);
      return op inside {OP_SLL, OP_SRL, OP_SRA};
   endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational decode of ALUOp/funct3/funct7/use_imm into the
// ALU Operation code plus branch-invert, branch and illegal flags.
module alu_issue_decode
   import alu_issue_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       use_imm,
   output logic [3:0] opcode,
   output logic       bne_inv,
   output logic       is_branch,
   output logic       illegal
);

   logic unused_f7;
   assign unused_f7 = ^{funct7[6], funct7[4:0]};

   always_comb begin
      opcode    = OP_ADD;
      bne_inv   = 1'b0;
      is_branch = 1'b0;
      illegal   = 1'b0;
      case (alu_op_e'(alu_op))
         ALU_OP_MEM: opcode = OP_ADD;
         ALU_OP_BRANCH: begin
            is_branch = 1'b1;
            case (funct3)
               3'b000: opcode = OP_BEQ;
               3'b001: begin
                  opcode  = OP_BEQ;
                  bne_inv = 1'b1;
               end
               3'b100: opcode = OP_BLT;
               3'b101: opcode = OP_BGE;
               default: begin
                  is_branch = 1'b0;
                  illegal   = 1'b1;
               end
            endcase
         end
         ALU_OP_ARITH: begin
            case (funct3)
               3'b000: opcode = (funct7[5] && !use_imm) ? OP_SUB : OP_ADD;
               3'b001: opcode = OP_SLL;
               3'b010: opcode = OP_SLT;
               3'b100: opcode = OP_XOR;
               3'b101: opcode = funct7[5] ? OP_SRA : OP_SRL;
               3'b110: opcode = OP_OR;
               3'b111: opcode = OP_AND;
               default: illegal = 1'b1;
            endcase
         end
         ALU_OP_LUI: opcode = OP_LUI;
         default: opcode = OP_ADD;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: ALU initiator with a registered issue stage and registered result stage.
// Define ALU_ISSUE_FWD_EN to forward in-flight results into operands at accept.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               alu_op,
   input  logic [2:0]               funct3,
   input  logic [6:0]               funct7,
   input  logic                     use_imm,
   input  logic                     is_jalr,
   input  logic [DATA_WIDTH-1:0]    rs1_data,
   input  logic [DATA_WIDTH-1:0]    rs2_data,
   input  logic [DATA_WIDTH-1:0]    imm,
   input  logic [4:0]               rs1_idx,
   input  logic [4:0]               rs2_idx,
   input  logic [4:0]               rd_idx,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     Jalr,
   input  logic [DATA_WIDTH-1:0]    ALUResult,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    result,
   output logic                     branch_taken,
   output logic                     illegal
);

   issue_s1_t             s1, s1_next;
   logic                  s1_valid, s2_valid;
   logic                  adv1, adv2, accept, s2_load;
   logic [3:0]            dec_op;
   logic                  dec_bne_inv, dec_is_branch, dec_illegal;
   logic [DATA_WIDTH-1:0] fwd_a, fwd_b, src_b_sel, res_fin;

   assign adv2     = !s2_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1 && !flush;
   assign accept   = in_valid && in_ready;
   assign s2_load  = !flush && adv2 && s1_valid;

   alu_issue_decode u_decode (
      .alu_op    (alu_op),
      .funct3    (funct3),
      .funct7    (funct7),
      .use_imm   (use_imm),
      .opcode    (dec_op),
      .bne_inv   (dec_bne_inv),
      .is_branch (dec_is_branch),
      .illegal   (dec_illegal)
   );

`ifdef ALU_ISSUE_FWD_EN
   logic [4:0] s2_rd;

   always_ff @(posedge clk) begin
      if (!rst_n)       s2_rd <= '0;
      else if (s2_load) s2_rd <= s1.rd;
   end

   // The op in s1 is on the ALU right now, so its value is ALUResult; s1 is younger than s2.
   always_comb begin
      fwd_a = rs1_data;
      fwd_b = rs2_data;
      if (s1_valid && s1.rd != 5'd0 && s1.rd == rs1_idx)      fwd_a = ALUResult;
      else if (s2_valid && s2_rd != 5'd0 && s2_rd == rs1_idx) fwd_a = result;
      if (s1_valid && s1.rd != 5'd0 && s1.rd == rs2_idx)      fwd_b = ALUResult;
      else if (s2_valid && s2_rd != 5'd0 && s2_rd == rs2_idx) fwd_b = result;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{rs1_idx, rs2_idx, s1.rd};
   assign fwd_a = rs1_data;
   assign fwd_b = rs2_data;
`endif

   always_comb begin
      src_b_sel         = (use_imm || alu_op == ALU_OP_LUI) ? imm : fwd_b;
      s1_next           = ISSUE_S1_RST;
      s1_next.src_a     = fwd_a;
      s1_next.op        = alu_opcode_e'(dec_op);
      s1_next.src_b     = is_shift_op(s1_next.op) ?
                          {{(DATA_WIDTH-5){1'b0}}, src_b_sel[4:0]} : src_b_sel;
      s1_next.jalr      = (alu_op == ALU_OP_MEM) && is_jalr;
      s1_next.bne_inv   = dec_bne_inv;
      s1_next.is_branch = dec_is_branch;
      s1_next.illegal   = dec_illegal;
      s1_next.rd        = rd_idx;
   end

   // BNE runs on the ALU as BEQ; the sense is flipped when the result is captured.
   assign res_fin = ALUResult ^ {{(DATA_WIDTH-1){1'b0}}, s1.bne_inv};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid     <= 1'b0;
         s2_valid     <= 1'b0;
         s1           <= ISSUE_S1_RST;
         result       <= '0;
         branch_taken <= 1'b0;
         illegal      <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (adv1)   s1_valid <= in_valid;
         if (accept) s1       <= s1_next;
         if (adv2)   s2_valid <= s1_valid;
         if (s2_load) begin
            result       <= res_fin;
            branch_taken <= s1.is_branch && res_fin[0];
            illegal      <= s1.illegal;
         end
      end
   end

   assign SrcA      = s1.src_a;
   assign SrcB      = s1.src_b;
   assign Operation = s1.op;
   assign Jalr      = s1.jalr;
   assign out_valid = s2_valid;

endmodule
